// File: rtl/mac_accum_if.sv
// Bundle between mult32x32 / result consumer and mac_accum. The design side
// uses the slave modport; the driver of products and consumer of results uses master.
interface mac_accum_if #(
    parameter int PWIDTH    = 64,
    parameter int ACC_WIDTH = 80,
    parameter int LWIDTH    = 16
);
    // Result handshake: o_acc/o_acc_vld are held while o_acc_vld=1 and
    // i_acc_rdy=0; a transfer happens on a rising edge where both are 1.
    logic                 i_start;
    logic [LWIDTH-1:0]    i_len;
    logic                 i_ns;
    logic                 i_prod_vld;
    logic [PWIDTH-1:0]    i_product;
    logic                 o_busy;
    logic [ACC_WIDTH-1:0] o_acc;
    logic                 o_acc_vld;
    logic                 i_acc_rdy;
    logic                 o_ovf;
    logic [1:0]           o_state;

    modport master (
        output i_start, i_len, i_ns, i_prod_vld, i_product, i_acc_rdy,
        input  o_busy, o_acc, o_acc_vld, o_ovf, o_state
    );

    modport slave (
        input  i_start, i_len, i_ns, i_prod_vld, i_product, i_acc_rdy,
        output o_busy, o_acc, o_acc_vld, o_ovf, o_state
    );
endinterface

// File: rtl/mac_accum.sv
// Frame accumulator for the MAC datapath: sums a programmed number of valid
// products (signed or unsigned) into a wide register, with wrap or saturate.
module mac_accum #(
    parameter int PWIDTH    = 64,
    parameter int ACC_WIDTH = 80,
    parameter int LWIDTH    = 16,
    parameter bit SAT       = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    mac_accum_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [ACC_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [ACC_WIDTH-1:0] MAX_S    = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] MIN_S    = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_e               state_q, state_d;
    logic [LWIDTH-1:0]    len_q, len_d;
    logic [LWIDTH-1:0]    cnt_q, cnt_d;
    logic [LWIDTH-1:0]    cnt_inc;
    logic                 ns_q, ns_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] res_q, res_d;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_now;

    // Extension uses the frame's latched signedness, not the live i_ns.
    always_comb begin
        ext = ns_q ? ACC_WIDTH'($signed(bus.i_product)) : ACC_WIDTH'(bus.i_product);
        sum = {1'b0, acc_q} + {1'b0, ext};
        if (ns_q) begin
            ovf_now = (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            ovf_now = sum[ACC_WIDTH];
        end
        cnt_inc = cnt_q + LWIDTH'(1);
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ns_d    = ns_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    len_d = bus.i_len;
                    ns_d  = bus.i_ns;
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (bus.i_len == '0) begin
                        res_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (bus.i_prod_vld) begin
                    cnt_d = cnt_inc;
                    // Once saturated, the accumulator is frozen for the frame.
                    if (SAT && ovf_q) begin
                        acc_d = acc_q;
                    end else if (ovf_now) begin
                        ovf_d = 1'b1;
                        if (SAT) begin
                            acc_d = ns_q ? (acc_q[ACC_WIDTH-1] ? MIN_S : MAX_S) : ALL_ONES;
                        end else begin
                            acc_d = sum[ACC_WIDTH-1:0];
                        end
                    end else begin
                        acc_d = sum[ACC_WIDTH-1:0];
                    end
                    if (cnt_inc == len_q) begin
                        res_d   = acc_d;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.i_acc_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ns_q    <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ns_q    <= ns_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_acc_vld = (state_q == S_DONE);
    assign bus.o_acc     = res_q;
    assign bus.o_ovf     = ovf_q;
    assign bus.o_state   = state_q;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: three instances (80-bit wrap, 64-bit wrap,
// 64-bit saturate) share one stimulus stream and are checked against hand values.
module tb_mac_accum;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [15:0] len;
    logic        ns;
    logic        vld;
    logic [63:0] prod;
    logic        rdy;

    int checks;
    int errors;

    mac_accum_if #(.PWIDTH(64), .ACC_WIDTH(80), .LWIDTH(16)) bus0 ();
    mac_accum_if #(.PWIDTH(64), .ACC_WIDTH(64), .LWIDTH(16)) bus1 ();
    mac_accum_if #(.PWIDTH(64), .ACC_WIDTH(64), .LWIDTH(16)) bus2 ();

    assign bus0.i_start = start;  assign bus1.i_start = start;  assign bus2.i_start = start;
    assign bus0.i_len   = len;    assign bus1.i_len   = len;    assign bus2.i_len   = len;
    assign bus0.i_ns    = ns;     assign bus1.i_ns    = ns;     assign bus2.i_ns    = ns;
    assign bus0.i_prod_vld = vld; assign bus1.i_prod_vld = vld; assign bus2.i_prod_vld = vld;
    assign bus0.i_product  = prod; assign bus1.i_product = prod; assign bus2.i_product = prod;
    assign bus0.i_acc_rdy  = rdy; assign bus1.i_acc_rdy  = rdy; assign bus2.i_acc_rdy  = rdy;

    mac_accum #(.PWIDTH(64), .ACC_WIDTH(80), .LWIDTH(16), .SAT(1'b0)) u0 (
        .i_clk(clk), .i_rstn(rstn), .bus(bus0.slave));
    mac_accum #(.PWIDTH(64), .ACC_WIDTH(64), .LWIDTH(16), .SAT(1'b0)) u1 (
        .i_clk(clk), .i_rstn(rstn), .bus(bus1.slave));
    mac_accum #(.PWIDTH(64), .ACC_WIDTH(64), .LWIDTH(16), .SAT(1'b1)) u2 (
        .i_clk(clk), .i_rstn(rstn), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Start cycle also presents a junk product that must not be summed.
    task automatic begin_frame(input logic [15:0] l, input logic n);
        start = 1'b1; len = l; ns = n; vld = 1'b1; prod = 64'hDEAD_BEEF_0000_0077;
        tick();
        start = 1'b0; vld = 1'b0;
    endtask

    task automatic push(input logic [63:0] p);
        vld = 1'b1; prod = p;
        tick();
        vld = 1'b0;
    endtask

    task automatic handshake();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rstn = 1'b0; start = 1'b0; len = '0; ns = 1'b0; vld = 1'b0; prod = '0; rdy = 1'b0;
        tick(); tick();
        chk("reset_busy", bus0.o_busy, 0);
        chk("reset_acc", bus0.o_acc, 0);
        chk("reset_vld", bus0.o_acc_vld, 0);
        chk("reset_ovf", bus0.o_ovf, 0);
        rstn = 1'b1;
        tick();

        // Unsigned 1+2+3+4, back-to-back
        begin_frame(16'd4, 1'b0);
        push(64'd1); push(64'd2); push(64'd3);
        chk("u4_vld_early", bus0.o_acc_vld, 0);
        push(64'd4);
        chk("u4_vld", bus0.o_acc_vld, 1);
        chk("u4_acc", bus0.o_acc, 80'd10);
        chk("u4_ovf", bus0.o_ovf, 0);
        handshake();
        chk("u4_vld_drop", bus0.o_acc_vld, 0);
        chk("u4_idle", bus0.o_busy, 0);
        chk("u4_acc_held", bus0.o_acc, 80'd10);

        // Signed -1 + 5 with three bubbles
        begin_frame(16'd2, 1'b1);
        push(64'hFFFF_FFFF_FFFF_FFFF);
        tick(); tick(); tick();
        push(64'd5);
        chk("s2_vld", bus0.o_acc_vld, 1);
        chk("s2_acc", bus0.o_acc, 80'd4);
        chk("s2_acc_sat64", bus2.o_acc, 80'd4);
        handshake();

        // Same products unsigned
        begin_frame(16'd2, 1'b0);
        push(64'hFFFF_FFFF_FFFF_FFFF);
        tick(); tick(); tick();
        push(64'd5);
        chk("u2_acc", bus0.o_acc, 80'h1_0000_0000_0000_0004);
        chk("u2_ovf", bus0.o_ovf, 0);
        chk("u2_acc_w64", bus1.o_acc, 80'd4);
        chk("u2_ovf_w64", bus1.o_ovf, 1);
        chk("u2_acc_s64", bus2.o_acc, 80'hFFFF_FFFF_FFFF_FFFF);
        handshake();

        // Three times 2^63 unsigned
        begin_frame(16'd3, 1'b0);
        push(64'h8000_0000_0000_0000);
        push(64'h8000_0000_0000_0000);
        push(64'h8000_0000_0000_0000);
        chk("big_acc", bus0.o_acc, 80'h1_8000_0000_0000_0000);
        chk("big_ovf", bus0.o_ovf, 0);
        chk("big_acc_w64", bus1.o_acc, 80'h8000_0000_0000_0000);
        chk("big_ovf_w64", bus1.o_ovf, 1);
        chk("big_acc_s64", bus2.o_acc, 80'hFFFF_FFFF_FFFF_FFFF);

        // Backpressure in DONE with noise on vld/start
        for (int i = 0; i < 5; i++) begin
            rdy = 1'b0; vld = 1'b1; prod = 64'd123; start = 1'b1; len = 16'd9;
            tick();
            chk("bp_vld", bus0.o_acc_vld, 1);
            chk("bp_acc", bus0.o_acc, 80'h1_8000_0000_0000_0000);
        end
        vld = 1'b0; start = 1'b0;
        handshake();
        chk("bp_vld_drop", bus0.o_acc_vld, 0);
        chk("bp_idle", bus0.o_busy, 0);

        // New frame right away, aborted by reset after an overflow in u1
        begin_frame(16'd5, 1'b0);
        push(64'hFFFF_FFFF_FFFF_FFFF);
        push(64'hFFFF_FFFF_FFFF_FFFF);
        chk("abort_busy", bus0.o_busy, 1);
        chk("abort_ovf_w64", bus1.o_ovf, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("abort_rst_busy", bus0.o_busy, 0);
        chk("abort_rst_acc", bus0.o_acc, 0);
        chk("abort_rst_vld", bus0.o_acc_vld, 0);
        chk("abort_rst_ovf_w64", bus1.o_ovf, 0);
        vld = 1'b1; prod = 64'd7;
        tick(); tick(); tick();
        vld = 1'b0;
        chk("abort_no_vld", bus0.o_acc_vld, 0);
        chk("abort_no_busy", bus0.o_busy, 0);

        // Zero-length frame
        begin_frame(16'd0, 1'b0);
        chk("len0_vld", bus0.o_acc_vld, 1);
        chk("len0_acc", bus0.o_acc, 0);
        chk("len0_busy", bus0.o_busy, 1);
        handshake();

        // Unsigned overflow at 64 bits
        begin_frame(16'd2, 1'b0);
        push(64'hFFFF_FFFF_FFFF_FFFF);
        push(64'd2);
        chk("uo_acc80", bus0.o_acc, 80'h1_0000_0000_0000_0001);
        chk("uo_ovf80", bus0.o_ovf, 0);
        chk("uo_acc_w64", bus1.o_acc, 80'd1);
        chk("uo_ovf_w64", bus1.o_ovf, 1);
        chk("uo_acc_s64", bus2.o_acc, 80'hFFFF_FFFF_FFFF_FFFF);
        chk("uo_ovf_s64", bus2.o_ovf, 1);
        handshake();

        // Signed positive overflow, then a later product while clamped
        begin_frame(16'd3, 1'b1);
        push(64'h7FFF_FFFF_FFFF_FFFF);
        push(64'd1);
        push(64'hFFFF_FFFF_FFFF_FFFF);
        chk("sp_acc80", bus0.o_acc, 80'h7FFF_FFFF_FFFF_FFFF);
        chk("sp_ovf80", bus0.o_ovf, 0);
        chk("sp_acc_w64", bus1.o_acc, 80'h7FFF_FFFF_FFFF_FFFF);
        chk("sp_ovf_w64", bus1.o_ovf, 1);
        chk("sp_acc_s64", bus2.o_acc, 80'h7FFF_FFFF_FFFF_FFFF);
        chk("sp_ovf_s64", bus2.o_ovf, 1);
        handshake();

        // Signed negative overflow
        begin_frame(16'd2, 1'b1);
        push(64'h8000_0000_0000_0000);
        push(64'hFFFF_FFFF_FFFF_FFFF);
        chk("sn_acc80", bus0.o_acc, 80'hFFFF_7FFF_FFFF_FFFF_FFFF);
        chk("sn_acc_w64", bus1.o_acc, 80'h7FFF_FFFF_FFFF_FFFF);
        chk("sn_acc_s64", bus2.o_acc, 80'h8000_0000_0000_0000);
        chk("sn_ovf_s64", bus2.o_ovf, 1);
        handshake();
        chk("end_idle", bus0.o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
